pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Multi-cycle stage sequencer for the RISC-Net pipeline. Drives the one-hot chip-select (`cs`) inputs of the fetch, decode, execute, memory and writeback stage modules so that exactly one stage is active per cycle. Stretches the fetch and memory stages until the memory handshake completes, skips the memory stage for non-memory instructions, and stops on a halt instruction. Sits at the top of the pipeline beside the register file and instruction/data memory.

## Interface

**Parameters**
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.
- `MEM_TIMEOUT`, default 255: maximum number of wait cycles in FETCH or MEMORY before a fault. Legal range is 1..255.

**Ports**
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: in IDLE, begins execution.
- `mem_ready`, input, 1: memory access complete; sampled in FETCH and MEMORY only.
- `is_halt`, input, 1: decoder flag; sampled in DECODE only.
- `needs_mem`, input, 1: decoder flag; sampled in DECODE only.
- `resume`, input, 1: in HALT, continues execution.
- `clear`, input, 1: synchronous return to IDLE from any state.
- `cs_fetch`, `cs_decode`, `cs_execute`, `cs_memory`, `cs_writeback`, output, 1 each: stage enables.
- `busy`, output, 1: state is FETCH through WRITEBACK.
- `halted`, output, 1: state is HALT.
- `fault`, output, 1: state is FAULT.
- `state`, output, 3: current state encoding.
- `instr_count`, output, `COUNT_WIDTH`: number of retired instructions.

## Operation

- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Moore machine. Every output is decoded from the registered state, so no input affects an output in the same cycle. `cs_*` is one-hot in states 1–5 and all-zero in states 0, 6 and 7.
- Transitions, evaluated in priority order with `clear` highest:
  - Any state with `clear`=1 → IDLE. The wait counter is zeroed; `instr_count` is unchanged.
  - IDLE: `start`=1 → FETCH; otherwise hold.
  - FETCH: `mem_ready`=1 → DECODE. Otherwise, if `wait_cnt`==`MEM_TIMEOUT`-1 → FAULT; otherwise hold and increment `wait_cnt`.
  - DECODE (1 cycle): latch `needs_mem` into `mem_pend`. `is_halt`=1 → HALT (takes precedence over `needs_mem`); otherwise → EXECUTE.
  - EXECUTE (1 cycle): `mem_pend`=1 → MEMORY; otherwise → WRITEBACK.
  - MEMORY: same wait and timeout rules as FETCH, with exit to WRITEBACK.
  - WRITEBACK (1 cycle): `instr_count` += 1 on exit, wrapping modulo 2^`COUNT_WIDTH`; → FETCH.
  - HALT: `resume`=1 → FETCH; `start` is ignored. A halt instruction does not increment `instr_count`.
  - FAULT: hold until `clear`; `start` and `resume` are ignored.
- `wait_cnt` is 8 bits. It is zeroed on every state change and counts only in FETCH and MEMORY.
- `start`, `resume` and `mem_ready` are level-sampled. No edge detection is performed.

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE, all `cs_*`=0, `busy`=0, `halted`=0, `fault`=0, `instr_count`=0, `wait_cnt`=0, `mem_pend`=0. Reset asserted mid-instruction aborts the instruction immediately with no retirement.
- `start` high at edge N gives `cs_fetch`=1 in cycle N+1.
- Minimum instruction length with `mem_ready` held high:
  - 4 cycles without memory: F, D, E, W.
  - 5 cycles with memory: F, D, E, M, W.
- Each cycle `mem_ready` is low in FETCH or MEMORY adds exactly one cycle.
- Timeout: with `mem_ready` held low, FETCH lasts exactly `MEM_TIMEOUT` cycles, then FAULT.
- `mem_ready` rising on the same edge that would time out: `mem_ready` wins, no fault.
- `clear` and `start` both high in IDLE: the state stays IDLE.
- `mem_ready` outside FETCH and MEMORY has no effect.
- `instr_count` updates on the edge leaving WRITEBACK and is visible in the following FETCH cycle.

## Test plan

- **Reset and start:** reset, then `start` pulse with `mem_ready`=1 and `needs_mem`=0 → `cs` sequence fetch, decode, execute, writeback, fetch; `instr_count`=1 after 4 cycles; `busy`=1 from cycle 1.
- **Memory instruction with wait states:** `needs_mem`=1 in DECODE, `mem_ready` low for 3 MEMORY cycles → `cs_memory` high for 4 cycles, then writeback; instruction takes 8 cycles total.
- **Halt and resume:** `is_halt`=1 and `needs_mem`=1 in DECODE → HALT (`state`=6, `halted`=1, all `cs`=0, `instr_count` unchanged). Then `resume` → `cs_fetch` the next cycle.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_ready` stuck low in FETCH → `cs_fetch` high for exactly 4 cycles, then `fault`=1, `state`=7. Next, `start` → remains in FAULT; `clear` → IDLE.
- **Counter wrap and boundary:** `COUNT_WIDTH`=4, run 17 non-memory instructions → `instr_count`=1. Separately, `MEM_TIMEOUT`=4 with `mem_ready` rising on the 4th FETCH cycle → DECODE, no fault.
- **Reset and clear mid-operation:** assert `rst_n` low during MEMORY → all outputs return to reset values immediately (asynchronously). Assert `clear` during EXECUTE → IDLE next cycle with `instr_count` retained.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and its environment.
// slave: sequencer side (inputs start..clear; outputs cs_*, status, count).
interface pipeline_sequencer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic start;
  logic mem_ready;
  logic is_halt;
  logic needs_mem;
  logic resume;
  logic clear;
  logic cs_fetch;
  logic cs_decode;
  logic cs_execute;
  logic cs_memory;
  logic cs_writeback;
  logic busy;
  logic halted;
  logic fault;
  logic [2:0] state;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output start, mem_ready, is_halt,
    output needs_mem, resume, clear,
    input  cs_fetch, cs_decode, cs_execute,
    input  cs_memory, cs_writeback,
    input  busy, halted, fault,
    input  state, instr_count
  );

  modport slave (
    input  start, mem_ready, is_halt,
    input  needs_mem, resume, clear,
    output cs_fetch, cs_decode, cs_execute,
    output cs_memory, cs_writeback,
    output busy, halted, fault,
    output state, instr_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// One-hot stage sequencer: F/D/E/(M)/W with memory wait, halt, timeout fault.
// Ports: clk, rst_n (async low), sif (slave: control in, cs_*/status out).
module pipeline_sequencer #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipeline_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    FAULT     = 3'd7
  } state_t;

  // Last wait value before the access is declared lost.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic mem_pend_q, mem_pend_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    mem_pend_d = mem_pend_q;
    cnt_d      = cnt_q;
    if (sif.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sif.start) state_d = FETCH;
        end
        FETCH: begin
          if (sif.mem_ready) state_d = DECODE;
          else if (wait_q == WAIT_LAST) state_d = FAULT;
        end
        DECODE: begin
          mem_pend_d = sif.needs_mem;
          state_d = sif.is_halt ? HALT : EXECUTE;
        end
        EXECUTE: begin
          state_d = mem_pend_q ? MEMORY : WRITEBACK;
        end
        MEMORY: begin
          if (sif.mem_ready) state_d = WRITEBACK;
          else if (wait_q == WAIT_LAST) state_d = FAULT;
        end
        WRITEBACK: begin
          cnt_d   = cnt_q + 1'b1;
          state_d = FETCH;
        end
        HALT: begin
          if (sif.resume) state_d = FETCH;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = IDLE;
      endcase
    end
    // Wait count only runs while stalled in a memory-facing stage.
    wait_d = '0;
    if (!sif.clear && state_d == state_q &&
        (state_q == FETCH || state_q == MEMORY))
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      mem_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      mem_pend_q <= mem_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sif.cs_fetch     = (state_q == FETCH);
  assign sif.cs_decode    = (state_q == DECODE);
  assign sif.cs_execute   = (state_q == EXECUTE);
  assign sif.cs_memory    = (state_q == MEMORY);
  assign sif.cs_writeback = (state_q == WRITEBACK);
  assign sif.busy   = (state_q >= FETCH) && (state_q <= WRITEBACK);
  assign sif.halted = (state_q == HALT);
  assign sif.fault  = (state_q == FAULT);
  assign sif.state  = state_q;
  assign sif.instr_count = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (COUNT_WIDTH=4, MEM_TIMEOUT=4).
// Directed scenarios plus a randomized run against a stage-list model.
module tb_pipeline_sequencer;

  localparam int CW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.COUNT_WIDTH(CW)) sif ();

  pipeline_sequencer #(
    .COUNT_WIDTH(CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  typedef struct packed {
    logic [2:0] st;
    logic mr;
    logic nm;
    logic ih;
    logic rs;
    logic sr;
  } step_t;

  function automatic logic [4:0] cs_of(input logic [2:0] st);
    logic [4:0] top;
    top = 5'b10000;
    if (st >= 3'd1 && st <= 3'd5) return top >> (st - 3'd1);
    return 5'b00000;
  endfunction

  function automatic logic [4:0] cs_now();
    return {sif.cs_fetch, sif.cs_decode, sif.cs_execute,
            sif.cs_memory, sif.cs_writeback};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sif.start = 0;
    sif.mem_ready = 0;
    sif.is_halt = 0;
    sif.needs_mem = 0;
    sif.resume = 0;
    sif.clear = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic do_clear();
    sif.clear = 1;
    tick();
    sif.clear = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (sif.state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d want 0", sif.state);
    end
    n_run++;
    if (cs_now() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_cs got %b want 00000", cs_now());
    end
    n_run++;
    if ({sif.busy, sif.halted, sif.fault} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {sif.busy, sif.halted, sif.fault});
    end
    n_run++;
    if (sif.instr_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", sif.instr_count);
    end
  endtask

  task automatic test_start();
    logic [2:0] exp [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    logic [CW-1:0] ec;
    idle_in();
    sif.mem_ready = 1;
    sif.start = 1;
    tick();
    sif.start = 0;
    for (int i = 0; i < 5; i++) begin
      ec = (i == 4) ? 4'd1 : 4'd0;
      n_run++;
      if ({sif.state, cs_now(), sif.busy, sif.instr_count} !==
          {exp[i], cs_of(exp[i]), 1'b1, ec}) begin
        n_fail++;
        $display("FAIL start_seq[%0d] got st=%0d cs=%b busy=%b cnt=%0d want st=%0d cs=%b busy=1 cnt=%0d",
                 i, sif.state, cs_now(), sif.busy, sif.instr_count,
                 exp[i], cs_of(exp[i]), ec);
      end
      tick();
    end
    do_clear();
    n_run++;
    if (sif.state !== 3'd0) begin
      n_fail++;
      $display("FAIL start_clear got %0d want 0", sif.state);
    end
  endtask

  task automatic test_mem_wait();
    logic [2:0] exp [9] = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic rdy [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    int mcyc = 0;
    int bad = 0;
    idle_in();
    sif.start = 1;
    sif.mem_ready = 1;
    tick();
    sif.start = 0;
    for (int i = 0; i < 9; i++) begin
      if (sif.state !== exp[i]) bad++;
      if (sif.cs_memory === 1'b1) mcyc++;
      sif.mem_ready = rdy[i];
      sif.needs_mem = (i == 1);
      tick();
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mem_seq got %0d wrong cycles want 0", bad);
    end
    n_run++;
    if (mcyc != 4) begin
      n_fail++;
      $display("FAIL mem_cs_cycles got %0d want 4", mcyc);
    end
    sif.needs_mem = 0;
    do_clear();
  endtask

  task automatic test_halt();
    logic [CW-1:0] c0;
    idle_in();
    c0 = sif.instr_count;
    sif.start = 1;
    sif.mem_ready = 1;
    tick();
    sif.start = 0;
    tick();
    sif.is_halt = 1;
    sif.needs_mem = 1;
    tick();
    sif.is_halt = 0;
    sif.needs_mem = 0;
    n_run++;
    if ({sif.state, sif.halted, cs_now(), sif.busy} !==
        {3'd6, 1'b1, 5'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_enter got st=%0d h=%b cs=%b busy=%b want st=6 h=1 cs=00000 busy=0",
               sif.state, sif.halted, cs_now(), sif.busy);
    end
    n_run++;
    if (sif.instr_count !== c0) begin
      n_fail++;
      $display("FAIL halt_count got %0d want %0d", sif.instr_count, c0);
    end
    sif.start = 1;
    tick();
    sif.start = 0;
    n_run++;
    if (sif.state !== 3'd6) begin
      n_fail++;
      $display("FAIL halt_ignore_start got %0d want 6", sif.state);
    end
    sif.resume = 1;
    tick();
    sif.resume = 0;
    n_run++;
    if ({sif.state, sif.cs_fetch} !== {3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_resume got st=%0d csf=%b want st=1 csf=1",
               sif.state, sif.cs_fetch);
    end
    do_clear();
  endtask

  task automatic test_timeout();
    int fc = 0;
    idle_in();
    sif.start = 1;
    tick();
    sif.start = 0;
    for (int i = 0; i < TO + 1; i++) begin
      if (sif.cs_fetch === 1'b1) fc++;
      tick();
    end
    n_run++;
    if (fc != TO) begin
      n_fail++;
      $display("FAIL timeout_fetch_cycles got %0d want %0d", fc, TO);
    end
    n_run++;
    if ({sif.state, sif.fault, cs_now()} !== {3'd7, 1'b1, 5'b0}) begin
      n_fail++;
      $display("FAIL timeout_fault got st=%0d f=%b cs=%b want st=7 f=1 cs=00000",
               sif.state, sif.fault, cs_now());
    end
    sif.start = 1;
    sif.resume = 1;
    sif.mem_ready = 1;
    tick();
    tick();
    idle_in();
    n_run++;
    if (sif.state !== 3'd7) begin
      n_fail++;
      $display("FAIL fault_sticky got %0d want 7", sif.state);
    end
    do_clear();
    n_run++;
    if ({sif.state, sif.fault} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL fault_clear got st=%0d f=%b want st=0 f=0",
               sif.state, sif.fault);
    end
  endtask

  task automatic test_boundary();
    idle_in();
    sif.start = 1;
    tick();
    sif.start = 0;
    tick();
    tick();
    tick();
    n_run++;
    if (sif.state !== 3'd1) begin
      n_fail++;
      $display("FAIL boundary_fetch4 got %0d want 1", sif.state);
    end
    sif.mem_ready = 1;
    tick();
    n_run++;
    if ({sif.state, sif.fault} !== {3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL boundary_ready_wins got st=%0d f=%b want st=2 f=0",
               sif.state, sif.fault);
    end
    idle_in();
    do_clear();
  endtask

  task automatic test_wrap();
    do_reset();
    sif.mem_ready = 1;
    sif.start = 1;
    tick();
    sif.start = 0;
    repeat (17 * 4) tick();
    n_run++;
    if ({sif.state, sif.instr_count} !== {3'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL count_wrap got st=%0d cnt=%0d want st=1 cnt=1",
               sif.state, sif.instr_count);
    end
    idle_in();
    do_clear();
  endtask

  task automatic test_async_reset();
    idle_in();
    sif.start = 1;
    sif.mem_ready = 1;
    tick();
    sif.start = 0;
    tick();
    sif.needs_mem = 1;
    tick();
    sif.needs_mem = 0;
    sif.mem_ready = 0;
    tick();
    n_run++;
    if (sif.state !== 3'd4) begin
      n_fail++;
      $display("FAIL areset_reach_mem got %0d want 4", sif.state);
    end
    #2;
    rst_n = 0;
    #1;
    n_run++;
    if ({sif.state, cs_now(), sif.busy, sif.instr_count} !==
        {3'd0, 5'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL areset_immediate got st=%0d cs=%b busy=%b cnt=%0d want st=0 cs=00000 busy=0 cnt=0",
               sif.state, cs_now(), sif.busy, sif.instr_count);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_clear_exec();
    idle_in();
    sif.start = 1;
    sif.mem_ready = 1;
    tick();
    sif.start = 0;
    repeat (6) tick();
    n_run++;
    if (sif.state !== 3'd3) begin
      n_fail++;
      $display("FAIL clear_reach_exec got %0d want 3", sif.state);
    end
    sif.clear = 1;
    tick();
    n_run++;
    if ({sif.state, sif.instr_count} !== {3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL clear_exec got st=%0d cnt=%0d want st=0 cnt=1",
               sif.state, sif.instr_count);
    end
    sif.start = 1;
    tick();
    n_run++;
    if (sif.state !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_beats_start got %0d want 0", sif.state);
    end
    idle_in();
  endtask

  task automatic test_random();
    step_t q[$];
    step_t s;
    int fw, mw, hw;
    logic mem, hlt;
    logic [CW-1:0] ec;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      fw  = $urandom_range(0, TO - 1);
      mw  = $urandom_range(0, TO - 1);
      hw  = $urandom_range(0, 2);
      mem = 1'($urandom % 2);
      hlt = ($urandom % 6) == 0;
      for (int k = 0; k <= fw; k++) begin
        s = 6'($urandom);
        s.st = 3'd1;
        s.mr = (k == fw);
        q.push_back(s);
      end
      s = 6'($urandom);
      s.st = 3'd2;
      s.nm = mem;
      s.ih = hlt;
      q.push_back(s);
      if (hlt) begin
        for (int k = 0; k <= hw; k++) begin
          s = 6'($urandom);
          s.st = 3'd6;
          s.rs = (k == hw);
          q.push_back(s);
        end
      end else begin
        s = 6'($urandom);
        s.st = 3'd3;
        q.push_back(s);
        if (mem) begin
          for (int k = 0; k <= mw; k++) begin
            s = 6'($urandom);
            s.st = 3'd4;
            s.mr = (k == mw);
            q.push_back(s);
          end
        end
        s = 6'($urandom);
        s.st = 3'd5;
        q.push_back(s);
      end
    end
    sif.start = 1;
    tick();
    ec = '0;
    foreach (q[i]) begin
      n_run++;
      if ({sif.state, cs_now(), sif.instr_count} !==
          {q[i].st, cs_of(q[i].st), ec}) begin
        n_fail++;
        $display("FAIL random[%0d] got st=%0d cs=%b cnt=%0d want st=%0d cs=%b cnt=%0d",
                 i, sif.state, cs_now(), sif.instr_count,
                 q[i].st, cs_of(q[i].st), ec);
      end
      sif.mem_ready = q[i].mr;
      sif.needs_mem = q[i].nm;
      sif.is_halt   = q[i].ih;
      sif.resume    = q[i].rs;
      sif.start     = q[i].sr;
      tick();
      if (q[i].st == 3'd5) ec = ec + 1'b1;
    end
    idle_in();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1;
    idle_in();
    test_reset();
    test_start();
    test_mem_wait();
    test_halt();
    test_timeout();
    test_boundary();
    test_wrap();
    test_async_reset();
    test_clear_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
